// File: rtl/fir_uart_pkg.sv
// ---------------------------------------------------------------------------
// fir_uart_pkg
// Shared definitions for the UART->FIR->UART sample sequencer:
//   BYTE_W   width of one UART character
//   state_e  sequencer FSM encoding (IDLE..TX_DONE, 3 bits)
// ---------------------------------------------------------------------------
package fir_uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_BYTE  = 3'd1,
        START_FIR = 3'd2,
        WAIT_FIR  = 3'd3,
        LOAD_TX   = 3'd4,
        TX_ACK    = 3'd5,
        TX_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/fir_uart_byte_ser.sv
// ---------------------------------------------------------------------------
// fir_uart_byte_ser
// Holds the captured FIR result and presents it one byte at a time, MSB
// byte first, for the UART transmitter.
// Ports:
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset
//   load_i    capture result_i, restart at the most significant byte
//   result_i  FIR result to be serialised
//   adv_i     move on to the next byte (tx_cnt++)
//   byte_o    byte currently selected for transmission
//   last_o    the selected byte is the final one of the result
// ---------------------------------------------------------------------------
module fir_uart_byte_ser
    import fir_uart_pkg::*;
#(
    parameter int RESULT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [RESULT_W-1:0] result_i,
    input  logic                adv_i,
    output logic [BYTE_W-1:0]   byte_o,
    output logic                last_o
);

    localparam int NT    = RESULT_W / BYTE_W;
    localparam int TXC_W = (NT > 1) ? $clog2(NT) : 1;

    logic [RESULT_W-1:0] result_q;
    logic [TXC_W-1:0]    tx_cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            tx_cnt_q <= '0;
        end else if (load_i) begin
            result_q <= result_i;
            tx_cnt_q <= '0;
        end else if (adv_i) begin
            // Shifting left keeps the byte for tx_cnt in the top byte, which is
            // the same as selecting [RESULT_W-1-8*tx_cnt -: 8] of the original.
            result_q <= result_q << BYTE_W;
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end
    end

    assign byte_o = result_q[RESULT_W-1 -: BYTE_W];
    assign last_o = (tx_cnt_q == TXC_W'(NT - 1));

endmodule

// File: rtl/fir_uart_seq.sv
// ---------------------------------------------------------------------------
// fir_uart_seq
// Sequencer for the UART->FIR->UART sample path. Builds SAMPLE_W-bit samples
// from received bytes (MSB first), pulses the FIR start, captures the FIR
// result and sends it MSB byte first through the UART transmitter using its
// busy handshake. Every output is registered.
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   rx_ready_i   1-cycle pulse, rx_data_i valid
//   rx_data_i    received byte
//   fir_in_o     assembled sample, stable from fir_strt_o to the next sample
//   fir_strt_o   1-cycle pulse, start the FIR on fir_in_o
//   fir_valid_i  FIR result valid (only looked at in WAIT_FIR)
//   fir_out_i    FIR result
//   tx_busy_i    UART transmitter busy
//   tx_start_o   1-cycle pulse, send tx_data_o
//   tx_data_o    byte to transmit, held until the next tx_start_o
//   busy_o       high in every state except IDLE
//   err_to_o     1-cycle pulse, inter-byte timeout dropped a partial sample
//   err_ovr_o    1-cycle pulse, a byte arrived while not receiving, dropped
// ---------------------------------------------------------------------------
module fir_uart_seq
    import fir_uart_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int RESULT_W    = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rx_ready_i,
    input  logic [BYTE_W-1:0]   rx_data_i,
    output logic [SAMPLE_W-1:0] fir_in_o,
    output logic                fir_strt_o,
    input  logic                fir_valid_i,
    input  logic [RESULT_W-1:0] fir_out_i,
    input  logic                tx_busy_i,
    output logic                tx_start_o,
    output logic [BYTE_W-1:0]   tx_data_o,
    output logic                busy_o,
    output logic                err_to_o,
    output logic                err_ovr_o
);

    localparam int NB     = SAMPLE_W / BYTE_W;
    localparam int BCNT_W = $clog2(NB + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(NB - 1);

    state_e              state_q;
    logic [SAMPLE_W-1:0] shift_q;
    logic [SAMPLE_W-1:0] shift_d;
    logic [BCNT_W-1:0]   byte_cnt_q;
    logic [TMR_W-1:0]    timer_q;
    logic [SAMPLE_W-1:0] fir_in_q;
    logic                fir_strt_q;
    logic                tx_start_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                busy_q;
    logic                err_to_q;
    logic                err_ovr_q;

    logic                ser_load;
    logic                ser_adv;
    logic [BYTE_W-1:0]   ser_byte;
    logic                ser_last;

    // New byte enters at the LSB; the oldest byte falls off the top, so a
    // stale partial sample is flushed by the next complete one.
    assign shift_d = SAMPLE_W'({shift_q, rx_data_i});

    // Result capture and byte advance are driven from the same state/input
    // conditions that move the FSM, keeping the selector in step with it.
    assign ser_load = (state_q == WAIT_FIR) && fir_valid_i;
    assign ser_adv  = (state_q == TX_DONE) && !tx_busy_i;

    fir_uart_byte_ser #(
        .RESULT_W (RESULT_W)
    ) u_byte_ser (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (ser_load),
        .result_i (fir_out_i),
        .adv_i    (ser_adv),
        .byte_o   (ser_byte),
        .last_o   (ser_last)
    );

    // NOTE: the pulse outputs get a default of 0 at the top of the clocked
    // branch, so each case arm only states when a pulse fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            fir_in_q   <= '0;
            fir_strt_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            fir_strt_q <= 1'b0;
            tx_start_q <= 1'b0;
            err_to_q   <= 1'b0;
            err_ovr_q  <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (rx_ready_i) begin
                        shift_q    <= shift_d;
                        byte_cnt_q <= BCNT_W'(1);
                        timer_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= (NB == 1) ? START_FIR : GET_BYTE;
                    end
                end

                GET_BYTE: begin
                    // A byte in the timeout cycle wins over the timeout.
                    if (rx_ready_i) begin
                        shift_q    <= shift_d;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        timer_q    <= '0;
                        if (byte_cnt_q == BCNT_LAST) begin
                            state_q <= START_FIR;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        err_to_q   <= 1'b1;
                        busy_q     <= 1'b0;
                        timer_q    <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                START_FIR: begin
                    fir_in_q   <= shift_q;
                    fir_strt_q <= 1'b1;
                    state_q    <= WAIT_FIR;
                end

                WAIT_FIR: begin
                    if (fir_valid_i) begin
                        state_q <= LOAD_TX;
                    end
                end

                LOAD_TX: begin
                    if (!tx_busy_i) begin
                        tx_data_q  <= ser_byte;
                        tx_start_q <= 1'b1;
                        state_q    <= TX_ACK;
                    end
                end

                TX_ACK: begin
                    // Transmitter has latched the byte once it reports busy.
                    if (tx_busy_i) begin
                        state_q <= TX_DONE;
                    end
                end

                TX_DONE: begin
                    if (!tx_busy_i) begin
                        if (ser_last) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOAD_TX;
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase

            // Bytes are judged by the state they arrive in, even if that state
            // is being left on the same edge.
            if (rx_ready_i && (state_q != IDLE) && (state_q != GET_BYTE)) begin
                err_ovr_q <= 1'b1;
            end
        end
    end

    assign fir_in_o   = fir_in_q;
    assign fir_strt_o = fir_strt_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = busy_q;
    assign err_to_o   = err_to_q;
    assign err_ovr_o  = err_ovr_q;

endmodule

// File: tb/tb_fir_uart_seq.sv
// ---------------------------------------------------------------------------
// tb_fir_uart_seq
// Directed bench for fir_uart_seq with SAMPLE_W=RESULT_W=16 and a short
// inter-byte timeout. The UART transmitter is played by hand-driven tx_busy.
// ---------------------------------------------------------------------------
module tb_fir_uart_seq;

    localparam int SW = 16;
    localparam int RW = 16;
    localparam int TO = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          rx_ready  = 1'b0;
    logic [7:0]    rx_data   = 8'h00;
    logic [SW-1:0] fir_in;
    logic          fir_strt;
    logic          fir_valid = 1'b0;
    logic [RW-1:0] fir_out   = '0;
    logic          tx_busy   = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy;
    logic          err_to;
    logic          err_ovr;

    int checks    = 0;
    int errors    = 0;
    int tx_starts = 0;
    int start_ref = 0;

    fir_uart_seq #(
        .SAMPLE_W    (SW),
        .RESULT_W    (RW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_ready_i  (rx_ready),
        .rx_data_i   (rx_data),
        .fir_in_o    (fir_in),
        .fir_strt_o  (fir_strt),
        .fir_valid_i (fir_valid),
        .fir_out_i   (fir_out),
        .tx_busy_i   (tx_busy),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .busy_o      (busy),
        .err_to_o    (err_to),
        .err_ovr_o   (err_ovr)
    );

    always #5 clk = ~clk;

    // tx_start is a full-cycle pulse, so a mid-cycle sample counts it once.
    always @(negedge clk) begin
        if (tx_start === 1'b1) tx_starts++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_start(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(tx_start), 32'd1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp));
    endtask

    // Full transmitter handshake for one byte: start seen, busy 1 for a few
    // cycles, busy 0, and one edge for the sequencer to see it drop.
    task automatic serve_byte(input string tag, input logic [7:0] exp);
        wait_tx_start(tag, exp);
        tick();
        check({tag, "_pulse1"}, 32'(tx_start), 32'd0);
        tx_busy = 1'b1;
        repeat (3) tick();
        check({tag, "_held"}, 32'(tx_data), 32'(exp));
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic fir_result(input logic [RW-1:0] r);
        fir_out   = r;
        fir_valid = 1'b1;
        tick();
        fir_valid = 1'b0;
        fir_out   = '0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_fir_in", 32'(fir_in), 32'h0);
        check("rst_fir_strt", 32'(fir_strt), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err_to", 32'(err_to), 32'h0);
        check("rst_err_ovr", 32'(err_ovr), 32'h0);
        rst_n = 1'b1;
        tick();

        // Sample assembly: 0x12, 0x34 -> 0x1234, start one cycle later
        send_byte(8'h12);
        check("t1_busy_first", 32'(busy), 32'd1);
        check("t1_strt_early", 32'(fir_strt), 32'd0);
        send_byte(8'h34);
        check("t1_strt_startfir", 32'(fir_strt), 32'd0);
        tick();
        check("t1_strt", 32'(fir_strt), 32'd1);
        check("t1_fir_in", 32'(fir_in), 32'h1234);
        tick();
        check("t1_strt_one_cycle", 32'(fir_strt), 32'd0);

        // Overrun during WAIT_FIR
        send_byte(8'h55);
        check("t5_err_ovr", 32'(err_ovr), 32'd1);
        tick();
        check("t5_err_ovr_pulse", 32'(err_ovr), 32'd0);
        check("t5_fir_in_kept", 32'(fir_in), 32'h1234);
        check("t5_busy", 32'(busy), 32'd1);

        // Result 0xBEEF with transmitter busy for 100 cycles in LOAD_TX
        tx_busy   = 1'b1;
        start_ref = tx_starts;
        fir_result(16'hBEEF);
        repeat (100) tick();
        check("t3_no_start_busy", 32'(tx_starts - start_ref), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        tx_busy = 1'b0;
        serve_byte("t2_b0", 8'hBE);
        serve_byte("t2_b1", 8'hEF);
        check("t2_idle", 32'(busy), 32'd0);
        check("t3_two_starts", 32'(tx_starts - start_ref), 32'd2);

        // Inter-byte timeout
        send_byte(8'h12);
        repeat (TO - 1) tick();
        check("t4_no_to_early", 32'(err_to), 32'd0);
        check("t4_busy_wait", 32'(busy), 32'd1);
        tick();
        check("t4_err_to", 32'(err_to), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);
        tick();
        check("t4_err_to_pulse", 32'(err_to), 32'd0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        tick();
        check("t4_strt", 32'(fir_strt), 32'd1);
        check("t4_fir_in", 32'(fir_in), 32'hABCD);
        fir_result(16'h0102);
        serve_byte("t4_b0", 8'h01);
        serve_byte("t4_b1", 8'h02);
        check("t4_done", 32'(busy), 32'd0);

        // Byte arriving in the timeout cycle is accepted
        send_byte(8'h11);
        repeat (TO - 1) tick();
        send_byte(8'h22);
        check("bnd_no_err_to", 32'(err_to), 32'd0);
        check("bnd_busy", 32'(busy), 32'd1);
        tick();
        check("bnd_strt", 32'(fir_strt), 32'd1);
        check("bnd_fir_in", 32'(fir_in), 32'h1122);
        fir_result(16'h7788);
        serve_byte("bnd_b0", 8'h77);
        serve_byte("bnd_b1", 8'h88);
        check("bnd_done", 32'(busy), 32'd0);

        // Asynchronous reset while in TX_DONE
        send_byte(8'h0A);
        send_byte(8'h0B);
        tick();
        check("t6_fir_in", 32'(fir_in), 32'h0A0B);
        fir_result(16'hCAFE);
        wait_tx_start("t6_b0", 8'hCA);
        tick();
        tx_busy = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_tx_data", 32'(tx_data), 32'h0);
        check("t6_rst_fir_in", 32'(fir_in), 32'h0);
        check("t6_rst_tx_start", 32'(tx_start), 32'd0);
        check("t6_rst_fir_strt", 32'(fir_strt), 32'd0);
        check("t6_rst_errs", 32'({err_to, err_ovr}), 32'd0);
        tx_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h33);
        send_byte(8'h44);
        tick();
        check("t6_new_strt", 32'(fir_strt), 32'd1);
        check("t6_new_fir_in", 32'(fir_in), 32'h3344);
        fir_result(16'h5566);
        serve_byte("t6_b0_new", 8'h55);
        serve_byte("t6_b1_new", 8'h66);
        check("t6_done", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
